// File: rtl/multicycle_ctrl_if.sv
// Control/instruction bundle between the multicycle ARM controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_ctrl_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM main controller: instruction sequencing FSM, NZCV flag register,
// condition evaluation and per-cycle datapath select/enable generation.
module multicycle_ctrl (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_if.master      bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t     state, state_nx;
  logic [3:0] flags;

  logic [3:0] cmd;
  logic       sbit;
  logic       condex;
  logic       flags_we;
  logic       cv_we;

  // Moore control bits before condition gating
  logic       nextpc, branch, regw, memw, aluop, irw;
  logic       adrsrc, alusrca;
  logic [1:0] alusrcb, resultsrc;
  logic [1:0] aluctl;

  assign cmd  = bus.Funct[4:1];
  assign sbit = bus.Funct[0];

  // State and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      flags <= '0;
    end else begin
      state <= state_nx;
      if (flags_we) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (cv_we) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_nx  = FETCH;
    nextpc    = 1'b0;
    branch    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    aluop     = 1'b0;
    irw       = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    unique case (state)
      FETCH: begin
        irw       = 1'b1;
        nextpc    = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        state_nx  = DECODE;
      end
      DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        unique case (bus.Op)
          2'b00:   state_nx = bus.Funct[5] ? EXECI : EXECR;
          2'b01:   state_nx = MEMADR;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR: begin
        alusrcb  = 2'b01;
        state_nx = sbit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adrsrc   = 1'b1;
        state_nx = MEMWB;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
        state_nx  = FETCH;
      end
      MEMWR: begin
        adrsrc   = 1'b1;
        memw     = 1'b1;
        state_nx = FETCH;
      end
      EXECR: begin
        aluop    = 1'b1;
        state_nx = ALUWB;
      end
      EXECI: begin
        alusrcb  = 2'b01;
        aluop    = 1'b1;
        state_nx = ALUWB;
      end
      ALUWB: begin
        regw     = 1'b1;
        state_nx = FETCH;
      end
      BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
        state_nx  = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  // Condition evaluation against the stored (pre-update) flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    condex = 1'b0;
    unique case (bus.Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // ALU decode: only EXECR/EXECI select a non-add operation
  always_comb begin
    aluctl = 2'b00;
    if (aluop) begin
      unique case (cmd)
        4'b0100: aluctl = 2'b00;
        4'b0010: aluctl = 2'b01;
        4'b0000: aluctl = 2'b10;
        4'b1100: aluctl = 2'b11;
        default: aluctl = 2'b00;
      endcase
    end
  end

  assign flags_we = aluop & sbit & condex;
  assign cv_we    = (cmd == 4'b0100) | (cmd == 4'b0010);

  // Write enables are held low for the whole reset assertion, including FETCH
  assign bus.PCWrite  = reset & (nextpc | (condex & (branch | (regw & (bus.Rd == 4'd15)))));
  assign bus.IRWrite  = reset & irw;
  assign bus.RegWrite = reset & regw & condex & (bus.Rd != 4'd15);
  assign bus.MemWrite = reset & memw & condex;

  assign bus.AdrSrc     = adrsrc;
  assign bus.ALUSrcA    = alusrca;
  assign bus.ALUSrcB    = alusrcb;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUControl = aluctl;
  assign bus.ImmSrc     = (bus.Op == 2'b11) ? 2'b00 : bus.Op;
  assign bus.RegSrc     = {(bus.Op == 2'b01) & ~sbit, (bus.Op == 2'b10)};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_pass;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {S_F, S_D, S_MA, S_MR, S_MWB, S_MWR, S_EXR, S_EXI, S_WB, S_BR} step_t;

  logic [3:0]  mflags;
  logic [15:0] outs;

  assign outs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc,
                 bus.ALUControl};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Even codes test a flag predicate, odd codes its negation; 1110/1111 are always/never
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: return c == 4'd14;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] cmd);
    case (cmd)
      4'd4:    return 2'd0;
      4'd2:    return 2'd1;
      4'd0:    return 2'd2;
      4'd12:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_outs(input step_t s, input logic [3:0] c, input logic [1:0] o,
                                           input logic [5:0] f, input logic [3:0] r, input logic [3:0] flg);
    logic pcw, irw, rw, mw, adr, sa;
    logic [1:0] sb, rs, ims, rgs, ac;
    bit ce;
    ce  = cond_ok(c, flg);
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; sa = 0; sb = 0; rs = 0; ac = 0;
    ims = (o == 2'd3) ? 2'd0 : o;
    rgs = {o == 2'd1 && !f[0], o == 2'd2};
    case (s)
      S_F:   begin pcw = 1; irw = 1; sa = 1; sb = 2; rs = 2; end
      S_D:   begin sa = 1; sb = 2; rs = 2; end
      S_MA:  sb = 1;
      S_MR:  adr = 1;
      S_MWB: begin rs = 1; rw = ce && r != 15; pcw = ce && r == 15; end
      S_MWR: begin adr = 1; mw = ce; end
      S_EXR: ac = alu_sel(f[4:1]);
      S_EXI: begin sb = 1; ac = alu_sel(f[4:1]); end
      S_WB:  begin rw = ce && r != 15; pcw = ce && r == 15; end
      S_BR:  begin sb = 1; rs = 2; pcw = ce; end
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, sa, sb, rs, ims, rgs, ac};
  endfunction

  task automatic build_seq(input logic [1:0] o, input logic [5:0] f, output step_t seq[$]);
    seq = {S_F, S_D};
    case (o)
      2'd0: begin seq.push_back(f[5] ? S_EXI : S_EXR); seq.push_back(S_WB); end
      2'd1: begin
        seq.push_back(S_MA);
        if (f[0]) begin seq.push_back(S_MR); seq.push_back(S_MWB); end
        else seq.push_back(S_MWR);
      end
      2'd2: seq.push_back(S_BR);
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH; entered and left just after a rising edge
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input bit rnd_af, input logic [3:0] af);
    step_t seq[$];
    build_seq(o, f, seq);
    bus.Cond = c; bus.Op = o; bus.Funct = f; bus.Rd = r;
    check("cpi", 16'(seq.size()), 16'((o == 2'd1) ? (f[0] ? 5 : 4) : (o == 2'd0) ? 4 : (o == 2'd2) ? 3 : 2));
    foreach (seq[i]) begin
      bus.ALUFlags = rnd_af ? 4'($urandom) : af;
      @(negedge clk);
      if (i == 0) check("flags", 16'(dut.flags), 16'(mflags));
      check("outs", outs, exp_outs(seq[i], c, o, f, r, mflags));
      if ((seq[i] == S_EXR || seq[i] == S_EXI) && f[0] && cond_ok(c, mflags)) begin
        mflags[3:2] = bus.ALUFlags[3:2];
        if (f[4:1] == 4'd4 || f[4:1] == 4'd2) mflags[1:0] = bus.ALUFlags[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    mflags   = '0;
    reset    = 1'b0;
    bus.Cond = 4'd14; bus.Op = 2'd0; bus.Funct = '0; bus.Rd = '0; bus.ALUFlags = '0;

    #12;
    check("reset_outs", outs, exp_outs(S_F, 4'd14, 2'd0, 6'd0, 4'd0, 4'd0) & 16'h0FFF);
    check("reset_flags", 16'(dut.flags), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // LDR, STR EQ with Z=0, SUBS then BNE, ADDS/ANDS flag hold, ADD to R15
    run_instr(4'd14, 2'd1, 6'b000001, 4'd3, 1'b0, 4'd0);
    run_instr(4'd0,  2'd1, 6'b000000, 4'd2, 1'b0, 4'd0);
    run_instr(4'd14, 2'd0, 6'b000101, 4'd1, 1'b0, 4'b0110);
    run_instr(4'd1,  2'd2, 6'b000000, 4'd0, 1'b0, 4'd0);
    run_instr(4'd14, 2'd0, 6'b001001, 4'd1, 1'b0, 4'b0011);
    run_instr(4'd14, 2'd0, 6'b100001, 4'd1, 1'b0, 4'b1011);
    check("ands_flags", 16'(dut.flags), 16'b1011);
    run_instr(4'd14, 2'd0, 6'b001000, 4'd15, 1'b0, 4'd0);
    run_instr(4'd14, 2'd3, 6'b000000, 4'd0, 1'b0, 4'd0);

    for (int i = 0; i < 200; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(4'($urandom), 2'($urandom), 6'($urandom), r, 1'b1, 4'd0);
    end

    // Make flags nonzero, then abort a store in MEMWR with reset
    run_instr(4'd14, 2'd0, 6'b001001, 4'd1, 1'b0, 4'b1111);
    bus.Cond = 4'd14; bus.Op = 2'd1; bus.Funct = 6'b000000; bus.Rd = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("memwr_pre", 16'(bus.MemWrite), 16'h1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_outs", outs, exp_outs(S_F, 4'd14, 2'd1, 6'b000000, 4'd4, 4'd0) & 16'h0FFF);
    check("abort_flags", 16'(dut.flags), 16'h0);
    mflags = '0;
    @(posedge clk);
    #1;
    check("held_outs", outs, exp_outs(S_F, 4'd14, 2'd1, 6'b000000, 4'd4, 4'd0) & 16'h0FFF);
    reset = 1'b1;
    run_instr(4'd14, 2'd2, 6'b000000, 4'd0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main controller for the multicycle ARM datapath. A state machine sequences fetch, decode, execute, memory access and writeback across several clocks of one shared ALU and one unified memory port. It holds the NZCV flag register and evaluates condition codes. Every cycle it drives the datapath mux selects and write enables, including the ImmSrc select for the immediate extender.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]: I bit is Funct[5], cmd is Funct[4:1], S/L bit is Funct[0].
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1 each  datapath write enables.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult register.
- ALUSrcA  out  1  0 = register A, 1 = PC.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE goes to MEMADR if Op=01, to EXECR if Op=00 and Funct[5]=0, to EXECI if Op=00 and Funct[5]=1, to BRANCH if Op=10. Op=11 returns to FETCH with no side effects.
  - MEMADR goes to MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD goes to MEMWB, then FETCH.
  - MEMWR goes to FETCH.
  - EXECR and EXECI go to ALUWB, then FETCH.
  - BRANCH goes to FETCH.
- Moore outputs per state. Any output not listed is 0 (selects 00).
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Instruction-decoded outputs, combinational from Op in every state:
  - ImmSrc = Op, with Op=11 giving 00.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01 and Funct[0]=0).
- ALUControl:
  - When ALUOp=0, ALUControl is 00 (add).
  - When ALUOp=1, cmd 0100 gives 00 (ADD), 0010 gives 01 (SUB), 0000 gives 10 (AND), 1100 gives 11 (ORR).
  - Any other cmd gives 00.
- CondEx is computed combinationally from Cond and the stored flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL (1110) is 1; 1111 is 0.
- Gated enables:
  - PCWrite = NextPC | (CondEx & (Branch | (RegW & Rd==15))).
  - RegWrite = RegW & CondEx & (Rd!=15).
  - MemWrite = MemW & CondEx.
  - FETCH and IRWrite are never condition-gated.
- Flags register, 4 bits:
  - Written at the clock edge leaving EXECR/EXECI, only when Funct[0]=1 and CondEx=1.
  - N and Z always load from ALUFlags[3:2].
  - C and V load from ALUFlags[1:0] only for ADD/SUB cmds; otherwise they hold.
  - CondEx in that cycle uses the pre-update flags.

## Timing
- Reset is asynchronous and active-low. While reset=0: state=FETCH, flags=0000, and PCWrite, IRWrite, RegWrite and MemWrite are forced 0. The remaining outputs show FETCH values.
- After reset rises, the first rising edge performs the fetch: the PC and IR are written.
- Cycles per instruction: branch 3, DP and STR 4, LDR 5, undefined (Op=11) 2.
- A taken branch or a DP write to R15 updates the PC at the end of BRANCH/ALUWB, overriding the FETCH-cycle PC+4.
- A failing condition turns the writeback cycle into a no-op: state sequencing is unchanged and no flags are written.
- Reset asserted mid-instruction aborts immediately. No write enable may be asserted after reset falls.

## Test plan
- Reset, then LDR (Op=01, Funct[0]=1, Cond=1110) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 only in MEMWB; ImmSrc=01; 5 cycles.
- STR with Cond=0000 (EQ) and Z=0 -> MemWrite stays 0 in MEMWR; next FETCH asserts PCWrite and IRWrite.
- SUBS register (cmd 0010, S=1) with ALUFlags=0110 -> ALUControl=01 in EXECR; flags=0110 afterwards; a following BNE (Cond=0001, Op=10) has PCWrite=0 in BRANCH.
- ANDS imm with ALUFlags=1011 over a prior flags value of 0011 -> flags=1011 from N/Z; C and V hold their previous values, which also read 11.
- ADD with Rd=15, Cond=AL -> RegWrite=0 and PCWrite=1 in ALUWB, ResultSrc=00.
- Reset pulled low during MEMWR -> MemWrite drops to 0 asynchronously; state=FETCH, flags=0000.
